k_sched_ctrl: RTL and testbench
===============================

# k_sched_ctrl

Sequencer for the SHA-256 round-constant path. Walks the K constant store from address 0 to K_LENGTH-1, absorbs the store's one-cycle read latency in a 2-entry prefetch buffer, and presents one constant per round to the compression engine over a valid/ready handshake. It sits between the K ROM and the round datapath. It also owns the per-block "constants done" indication.

## Interface
- K_LENGTH, 64, number of round constants per block; power of two, at least 4
- DATA_WIDTH, 32, constant word width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin a K sweep; honoured only in IDLE
- abort  in  1  cancel the current sweep; honoured in any state
- k_read_en  out  1  read strobe to the K store
- k_address  out  $clog2(K_LENGTH)  read address to the K store
- k_data  in  DATA_WIDTH  K store read data, valid the cycle after k_read_en
- k_out  out  DATA_WIDTH  constant for the current round (buffer head)
- k_round  out  $clog2(K_LENGTH)  round index of k_out
- k_valid  out  1  k_out/k_round valid
- k_ready  in  1  round engine accepts k_out this cycle
- busy  out  1  high in FETCH
- k_vector_complete  out  1  one-cycle pulse after the last constant is accepted

## Operation
- Reset (reset=0 at an edge): state=IDLE. Issue counter=0, accept counter=0, buffer count=0, in-flight=0. All outputs are 0, including k_address and k_out.
- States: IDLE, FETCH.
- IDLE->FETCH: start=1 and abort=0. Both counters clear on entry.
- FETCH->IDLE: the accept of round K_LENGTH-1, or abort=1. Abort takes priority.
- Issue rule, evaluated combinationally in FETCH:
  - k_read_en=1 when issued<K_LENGTH and (count + inflight - pop) < 2.
  - pop = k_valid & k_ready.
  - k_address = issued counter. issued increments on every k_read_en.
- Return path:
  - inflight is a 1-bit register set to k_read_en.
  - When inflight=1, k_data is written to the buffer tail, tagged with its round index.
  - The buffer never overflows by construction. An overflow is an assertion failure.
- Output:
  - k_valid = count!=0. k_out and k_round come from the head entry.
  - Head must hold stable while k_valid=1 and k_ready=0.
  - Push and pop in the same cycle are both allowed: count stays the same.
- Completion: the accept with k_round=K_LENGTH-1 sets k_vector_complete=1 for exactly the next cycle, and the state returns to IDLE.
- Abort:
  - Buffer, counters and inflight clear at the next edge. Any k_data returning on the following cycle is discarded.
  - No k_vector_complete pulse is produced.
  - start is ignored in the same cycle as abort.
- start while busy is ignored. k_ready while k_valid=0 has no effect.
- Arithmetic: issued and accepted counters are $clog2(K_LENGTH)+1 bits wide, so K_LENGTH is representable without wrap-around. k_address takes the low bits.

## Timing
- Edge E0 samples start. k_read_en=1, address 0, in the cycle after E0. k_data is captured at E2. k_valid=1 in the cycle after E2.
- With k_ready held at 1:
  - One constant is accepted per cycle, with no bubbles.
  - The last accept happens K_LENGTH-1 cycles after the first.
  - k_vector_complete is high in the cycle after the last accept.
  - busy is low from that same cycle.
- Back-pressure: at most 2 words are buffered, plus 0 in flight. Issue resumes in the cycle in which pop=1.
- Reset asserted mid-sweep behaves like abort and also zeroes outputs at the same edge.
- A new start is accepted in the cycle k_vector_complete is high, because the state is already IDLE.

## Structure
- Shared package sha256_pkg holds:
  - the state enum (IDLE, FETCH);
  - the K_LENGTH and DATA_WIDTH defaults;
  - the round-index width constant.
- One sub-module, k_prefetch_buf: a 2-entry FIFO with push/pop/count, storing {round, data}. It has a synchronous active-low reset and a flush input driven by abort.
- The controller FSM, the counters and the issue logic live in the top level.

## Test plan
- Streaming: reset, then start with k_ready=1 and the store returning data = 0x428a2f98 + address.
  - k_valid rises 2 cycles after start.
  - 64 consecutive accepts occur, with k_round 0..63 and matching data.
  - k_vector_complete is high exactly one cycle after round 63.
- Back-pressure: k_ready=0 for 5 cycles after the first k_valid.
  - Buffer count=2, k_read_en=0, and head remains round 0.
  - On k_ready=1, rounds continue with none lost or duplicated.
- Random k_ready with 50% duty: the bench sees all 64 rounds in order, and k_out is stable under stall every cycle.
- Abort during round 20 while a read is in flight:
  - The next cycle shows IDLE, k_valid=0 and busy=0.
  - The returning k_data is ignored and there is no k_vector_complete pulse.
  - A following start restarts at address 0.
- Reset at round 30, then a re-start: all outputs are 0 during reset, and the sweep restarts from round 0.
- start held high through a sweep and in the k_vector_complete cycle:
  - Mid-sweep starts are ignored.
  - The second sweep begins, with k_read_en at address 0, in the cycle after the complete pulse.

Source files
------------

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and defaults for the SHA-256 round-constant path.
//   k_state_e      : sequencer state (IDLE / FETCH)
//   K_LENGTH_DEF   : default number of round constants per block
//   DATA_WIDTH_DEF : default constant word width
//   ROUND_W_DEF    : width of a round index for the default K_LENGTH
package sha256_pkg;

    localparam int K_LENGTH_DEF   = 64;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ROUND_W_DEF    = $clog2(K_LENGTH_DEF);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } k_state_e;

endpackage

// File: rtl/k_prefetch_buf.sv
// k_prefetch_buf: 2-entry FIFO that absorbs the K store read latency.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   flush        : drop all entries at the next edge (abort)
//   push         : write push_data at the tail
//   push_data    : {round, data} entry
//   pop          : remove the head entry (ignored when empty)
//   head_data    : head entry, stable until popped
//   count        : number of stored entries (0..2)
module k_prefetch_buf #(
    parameter int WIDTH = 38
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests: pop needs data; push needs room unless the head leaves in the same cycle.
    always_comb begin
        pop_ok_s  = pop & (count_r != 2'd0);
        push_ok_s = push & ((count_r != 2'd2) | pop_ok_s);
    end

    // Storage, pointers and occupancy; flush wins over a concurrent push.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;

    k_prefetch_buf_chk u_chk (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .count (count_r)
    );

endmodule

// File: rtl/k_prefetch_buf_chk.sv
// k_prefetch_buf_chk: property checker for the 2-entry prefetch buffer.
//   clock, reset : clock and synchronous active-low reset of the buffer
//   flush        : buffer flush (a push under flush is discarded, not an overflow)
//   push, pop    : raw push/pop requests seen by the buffer
//   count        : current occupancy
module k_prefetch_buf_chk (
    input logic       clock,
    input logic       reset,
    input logic       flush,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);

    // A push into a full buffer without a simultaneous pop would lose a word.
    overflow_a: assert property (@(posedge clock) disable iff (!reset)
        !(push && !flush && !pop && (count == 2'd2)));

endmodule

// File: rtl/k_sched_ctrl.sv
// k_sched_ctrl: walks the K constant store 0..K_LENGTH-1 and hands one
// constant per round to the compression engine over valid/ready.
//   clock, reset      : rising-edge clock, synchronous active-low reset
//   start, abort      : begin a sweep (IDLE only) / cancel in any state
//   k_read_en         : read strobe to the K store
//   k_address         : K store read address
//   k_data            : K store data, valid the cycle after k_read_en
//   k_out, k_round    : head constant and its round index
//   k_valid, k_ready  : round handshake
//   busy              : sweep in progress
//   k_vector_complete : one-cycle pulse after the last constant is accepted
module k_sched_ctrl
    import sha256_pkg::*;
#(
    parameter int K_LENGTH   = K_LENGTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    output logic                        k_read_en,
    output logic [$clog2(K_LENGTH)-1:0] k_address,
    input  logic [DATA_WIDTH-1:0]       k_data,
    output logic [DATA_WIDTH-1:0]       k_out,
    output logic [$clog2(K_LENGTH)-1:0] k_round,
    output logic                        k_valid,
    input  logic                        k_ready,
    output logic                        busy,
    output logic                        k_vector_complete
);

    localparam int RW = $clog2(K_LENGTH);
    localparam int CW = RW + 1;
    localparam int EW = RW + DATA_WIDTH;

    k_state_e        state_r;
    k_state_e        state_next_s;
    logic [CW-1:0]   issued_r;
    logic [CW-1:0]   accepted_r;
    logic            inflight_r;
    logic [RW-1:0]   inflight_round_r;
    logic            complete_r;
    logic [1:0]      buf_count_s;
    logic [EW-1:0]   head_s;
    logic            valid_s;
    logic            pop_s;
    logic            start_sweep_s;
    logic            last_accept_s;
    logic            read_en_s;
    logic            busy_s;
    logic [2:0]      occupancy_s;
    logic [2:0]      limit_s;

    // Handshake decode and occupancy terms for the issue rule.
    always_comb begin
        valid_s       = (buf_count_s != 2'd0);
        pop_s         = valid_s & k_ready;
        start_sweep_s = (state_r == ST_IDLE) & start & ~abort;
        last_accept_s = (state_r == ST_FETCH) & pop_s & (accepted_r == CW'(K_LENGTH - 1));
        // count + inflight - pop < 2, rearranged so nothing goes negative.
        occupancy_s   = {1'b0, buf_count_s} + {2'b00, inflight_r};
        limit_s       = 3'd2 + {2'b00, pop_s};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort has priority over completion.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_sweep_s) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort || last_accept_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: busy and the read strobe (held off during reset).
    always_comb begin
        read_en_s = 1'b0;
        busy_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                busy_s = 1'b1;
                if (reset && (issued_r < CW'(K_LENGTH)) && (occupancy_s < limit_s)) begin
                    read_en_s = 1'b1;
                end else begin
                    read_en_s = 1'b0;
                end
            end
            ST_IDLE: begin
                read_en_s = 1'b0;
                busy_s    = 1'b0;
            end
            default: begin
                read_en_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Issue and accept counters; one bit wider than an address so K_LENGTH fits.
    always_ff @(posedge clock) begin
        if (!reset) begin
            issued_r   <= '0;
            accepted_r <= '0;
        end else if (abort || start_sweep_s) begin
            issued_r   <= '0;
            accepted_r <= '0;
        end else begin
            if (read_en_s) begin
                issued_r <= issued_r + CW'(1);
            end
            if (pop_s) begin
                accepted_r <= accepted_r + CW'(1);
            end
        end
    end

    // In-flight tracking: marks the cycle k_data is valid and carries its round tag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight_r       <= 1'b0;
            inflight_round_r <= '0;
        end else if (abort) begin
            inflight_r       <= 1'b0;
            inflight_round_r <= '0;
        end else begin
            inflight_r       <= read_en_s;
            inflight_round_r <= issued_r[RW-1:0];
        end
    end

    // Completion pulse, suppressed when the final accept coincides with abort.
    always_ff @(posedge clock) begin
        if (!reset) begin
            complete_r <= 1'b0;
        end else begin
            complete_r <= last_accept_s & ~abort;
        end
    end

    k_prefetch_buf #(
        .WIDTH (EW)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (abort),
        .push      (inflight_r),
        .push_data ({inflight_round_r, k_data}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (buf_count_s)
    );

    assign k_read_en         = read_en_s;
    assign k_address         = issued_r[RW-1:0];
    assign k_valid           = valid_s;
    assign k_out             = head_s[DATA_WIDTH-1:0];
    assign k_round           = head_s[EW-1:DATA_WIDTH];
    assign busy              = busy_s;
    assign k_vector_complete = complete_r;

endmodule

// File: tb/tb_k_sched_ctrl.sv
// tb_k_sched_ctrl: randomized self-checking bench for k_sched_ctrl against a
// transaction-level model (expected round sequence, outstanding-word bound,
// first-read/first-valid latency, completion pulse, stall stability).
module tb_k_sched_ctrl;
    import sha256_pkg::*;

    localparam int KL = K_LENGTH_DEF;
    localparam int RW = ROUND_W_DEF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          k_ready = 1'b0;
    logic          k_read_en;
    logic [RW-1:0] k_address;
    logic [31:0]   k_data = 32'd0;
    logic [31:0]   k_out;
    logic [RW-1:0] k_round;
    logic          k_valid;
    logic          busy;
    logic          k_vector_complete;

    logic [31:0]   rom [KL];
    logic          rst_q = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit          m_busy = 1'b0;
    bit          m_cmp_due = 1'b0;
    bit          m_stall = 1'b0;
    bit          m_first_v = 1'b0;
    bit          m_all_ready = 1'b0;
    bit          m_last = 1'b0;
    int          m_issued = 0;
    int          m_acc = 0;
    int          m_cyc = 0;
    int          m_first_acc = 0;
    logic [31:0] m_prev_out = 32'd0;
    logic [RW-1:0] m_prev_round = '0;

    k_sched_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .abort             (abort),
        .k_read_en         (k_read_en),
        .k_address         (k_address),
        .k_data            (k_data),
        .k_out             (k_out),
        .k_round           (k_round),
        .k_valid           (k_valid),
        .k_ready           (k_ready),
        .busy              (busy),
        .k_vector_complete (k_vector_complete)
    );

    always #5 clock = ~clock;

    // K store with one-cycle read latency
    always @(posedge clock) begin
        if (k_read_en) k_data <= rom[k_address];
        rst_q <= reset;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor and reference model, evaluated mid-cycle.
    always @(negedge clock) begin
        m_last = 1'b0;
        if (rst_q !== 1'b1) begin
            check_eq("rst_read_en", k_read_en, 0);
            check_eq("rst_address", k_address, 0);
            check_eq("rst_k_out", k_out, 0);
            check_eq("rst_k_round", k_round, 0);
            check_eq("rst_k_valid", k_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_complete", k_vector_complete, 0);
        end else begin
            check_eq("busy", busy, m_busy);
            check_eq("complete", k_vector_complete, m_cmp_due);
            if (!m_busy) begin
                check_eq("idle_valid", k_valid, 0);
                check_eq("idle_read_en", k_read_en, 0);
            end
            if (k_read_en) begin
                check_eq("address", k_address, m_issued[RW-1:0]);
                if (m_issued == 0) check_eq("first_read_cycle", m_cyc, 1);
                m_issued++;
            end
            if (m_stall) begin
                check_eq("stall_valid", k_valid, 1);
                check_eq("stall_k_out", k_out, m_prev_out);
                check_eq("stall_k_round", k_round, m_prev_round);
            end
            if (k_valid && !m_first_v) begin
                check_eq("first_valid_cycle", m_cyc, 3);
                m_first_v = 1'b1;
            end
            if (k_valid && k_ready) begin
                check_eq("round", k_round, m_acc);
                check_eq("data", k_out, rom[m_acc]);
                if (m_acc == 0) m_first_acc = m_cyc;
                if (m_acc == KL - 1) begin
                    m_last = 1'b1;
                    if (m_all_ready) check_eq("stream_span", m_cyc - m_first_acc, KL - 1);
                end
                m_acc++;
            end
            check_eq("outstanding_le2", (m_issued - m_acc) <= 2, 1);
            if (m_busy && !k_ready) m_all_ready = 1'b0;
            m_stall      = k_valid && !k_ready;
            m_prev_out   = k_out;
            m_prev_round = k_round;
        end
        // next-state of the model, from inputs sampled at the coming edge
        m_cmp_due = m_last && reset && !abort;
        if (!reset || abort) begin
            m_busy   = 1'b0;
            m_issued = 0;
            m_acc    = 0;
            m_stall  = 1'b0;
        end else if (!m_busy && start) begin
            m_busy      = 1'b1;
            m_issued    = 0;
            m_acc       = 0;
            m_cyc       = 0;
            m_first_v   = 1'b0;
            m_all_ready = 1'b1;
            m_stall     = 1'b0;
        end else if (m_last) begin
            m_busy  = 1'b0;
            m_stall = 1'b0;
        end
        if (m_busy) m_cyc++;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_rom(input bit rnd);
        for (int i = 0; i < KL; i++) rom[i] = rnd ? $urandom : (32'h428a2f98 + i);
    endtask

    task automatic wait_acc(input int n);
        int i = 0;
        while (m_acc < n && m_busy && i < 500) begin
            cyc();
            i++;
        end
        check_eq("reach_round", m_acc >= n, 1);
    endtask

    task automatic wait_idle();
        int i = 0;
        while (m_busy && i < 1000) begin
            cyc();
            i++;
        end
        check_eq("sweep_ends", m_busy, 0);
    endtask

    task automatic kick();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int i;
        fill_rom(1'b0);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        // streaming with k_ready held high
        k_ready = 1'b1;
        kick();
        wait_idle();
        check_eq("stream_count", m_acc, KL);
        repeat (2) cyc();

        // back-pressure for 5 cycles after the first k_valid
        kick();
        i = 0;
        while (!k_valid && i < 20) begin
            cyc();
            i++;
        end
        check_eq("bp_first_valid", k_valid, 1);
        k_ready = 1'b0;
        repeat (4) cyc();
        @(negedge clock);
        #1;
        check_eq("bp_read_en", k_read_en, 0);
        check_eq("bp_head_round", k_round, 0);
        check_eq("bp_buffered", m_issued - m_acc, 2);
        cyc();
        k_ready = 1'b1;
        wait_idle();
        check_eq("bp_count", m_acc, KL);
        repeat (2) cyc();

        // random k_ready, random constants
        fill_rom(1'b1);
        k_ready = 1'($urandom_range(0, 1));
        kick();
        i = 0;
        while (m_busy && i < 2000) begin
            k_ready = 1'($urandom_range(0, 1));
            cyc();
            i++;
        end
        check_eq("rand_count", m_acc, KL);
        k_ready = 1'b1;
        repeat (2) cyc();

        // abort at round 20 with a read in flight
        fill_rom(1'b0);
        kick();
        wait_acc(20);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        @(negedge clock);
        #1;
        check_eq("abort_valid", k_valid, 0);
        check_eq("abort_busy", busy, 0);
        repeat (3) cyc();
        kick();
        wait_idle();
        check_eq("abort_restart_count", m_acc, KL);
        repeat (2) cyc();

        // reset at round 30, then restart
        fill_rom(1'b1);
        kick();
        wait_acc(30);
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        kick();
        wait_idle();
        check_eq("reset_restart_count", m_acc, KL);
        repeat (2) cyc();

        // start held high through a sweep and the completion cycle
        start = 1'b1;
        i = 0;
        cyc();
        while (!k_vector_complete && i < 300) begin
            cyc();
            i++;
        end
        check_eq("held_complete_seen", k_vector_complete, 1);
        cyc();
        start = 1'b0;
        check_eq("held_restart_read_en", k_read_en, 1);
        check_eq("held_restart_address", k_address, 0);
        wait_idle();
        check_eq("held_second_count", m_acc, KL);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
